// File: rtl/retire_trace_buffer.sv
// Retirement trace buffer: classifies and numbers one commit-side event per cycle into a valid/ready FIFO.
// Optional build macro RETIRE_TRACE_NOP_FILTER_EN: NOP-class cycles are neither enqueued nor numbered.
module retire_trace_buffer #(
  parameter int DEPTH      = 8,
  parameter int MAX_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        reg_write,
  input  logic [3:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        hlt,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [1:0]  ev_kind,
  output logic        ev_load,
  output logic [31:0] ev_inum,
  output logic [15:0] ev_pc,
  output logic [3:0]  ev_reg,
  output logic [15:0] ev_addr,
  output logic [15:0] ev_value,
  output logic [31:0] inst_count,
  output logic [31:0] cycle_count,
  output logic [15:0] drop_count,
  output logic        halted,
  output logic        timeout
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW + 1)'(1);
  localparam logic [31:0] LAST_CYCLE = 32'(MAX_CYCLES - 1);
  localparam logic [1:0]  K_NOP      = 2'd0;
  localparam logic [1:0]  K_REG      = 2'd1;
  localparam logic [1:0]  K_STORE    = 2'd2;
  localparam logic [1:0]  K_HALT     = 2'd3;

  typedef enum logic [1:0] {S_CAPTURE, S_HALT_PEND, S_STOPPED} state_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic        load;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [3:0]  rg;
    logic [15:0] addr;
    logic [15:0] value;
  } entry_t;

  state_t      r_state;
  entry_t      r_mem [DEPTH];
  entry_t      r_pend;
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [31:0] r_inst_count;
  logic [31:0] r_cycle_count;
  logic [15:0] r_drop_count;
  logic        r_halted;
  logic        r_timeout;

  entry_t w_ev;
  entry_t w_push_data;
  entry_t w_out;
  logic   w_is_event;
  logic   w_full;
  logic   w_empty;
  logic   w_push;
  logic   w_pop;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    w_ev      = '0;
    w_ev.pc   = pc;
    w_ev.inum = r_inst_count;
    if (reg_write) begin
      w_ev.kind  = K_REG;
      w_ev.load  = mem_read;
      w_ev.rg    = write_reg;
      w_ev.value = write_data;
      w_ev.addr  = mem_read ? mem_addr : 16'h0000;
    end else if (hlt) begin
      w_ev.kind = K_HALT;
    end else if (mem_write) begin
      w_ev.kind  = K_STORE;
      w_ev.addr  = mem_addr;
      w_ev.value = mem_data;
    end
  end

`ifdef RETIRE_TRACE_NOP_FILTER_EN
  assign w_is_event = (w_ev.kind != K_NOP);
`else
  assign w_is_event = 1'b1;
`endif

  // Full is judged on the pointers before this cycle's pop, so a same-cycle pop never rescues an event.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && ev_ready;

  always_comb begin
    w_push      = 1'b0;
    w_push_data = w_ev;
    case (r_state)
      S_CAPTURE:   w_push = w_is_event && !w_full;
      S_HALT_PEND: begin
        w_push      = !w_full;
        w_push_data = r_pend;
      end
      default:     w_push = 1'b0;
    endcase
  end

  // NOTE: the event storage is not reset; the pointers alone define what is valid, and outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_CAPTURE;
      r_pend        <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_inst_count  <= '0;
      r_cycle_count <= '0;
      r_drop_count  <= '0;
      r_halted      <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case (r_state)
        S_CAPTURE: begin
          r_cycle_count <= r_cycle_count + 32'd1;
          if (w_is_event) begin
            r_inst_count <= r_inst_count + 32'd1;
            if (w_full) begin
              if (w_ev.kind == K_HALT) begin
                r_pend  <= w_ev;
                r_state <= S_HALT_PEND;
              end else if (r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
              end
            end else if (w_ev.kind == K_HALT) begin
              r_halted <= 1'b1;
              r_state  <= S_STOPPED;
            end
          end
          if (r_cycle_count == LAST_CYCLE) begin
            r_timeout <= 1'b1;
            r_state   <= S_STOPPED;
          end
        end
        S_HALT_PEND: begin
          if (!w_full) begin
            r_halted <= 1'b1;
            r_state  <= S_STOPPED;
          end
        end
        default: r_state <= S_STOPPED;
      endcase
    end
  end

  assign w_out       = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign ev_valid    = !w_empty;
  assign ev_kind     = w_out.kind;
  assign ev_load     = w_out.load;
  assign ev_inum     = w_out.inum;
  assign ev_pc       = w_out.pc;
  assign ev_reg      = w_out.rg;
  assign ev_addr     = w_out.addr;
  assign ev_value    = w_out.value;
  assign inst_count  = r_inst_count;
  assign cycle_count = r_cycle_count;
  assign drop_count  = r_drop_count;
  assign halted      = r_halted;
  assign timeout     = r_timeout;

endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Captures one retirement event per cycle from the CPU's commit-side signals (PC, register write-back, memory access, halt), classifies it, tags it with a sequential instruction number, and queues it in a small FIFO drained over a valid/ready port. It sits directly downstream of `cpu`, alongside the simulation bench. It gives the bench, or a future on-chip debug port, a lossless-where-possible, ordered retirement trace with cycle and instruction counters.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `MAX_CYCLES`, 100000: cycle limit after which capture stops and `timeout` asserts.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `pc`  in  16  PC of the retiring instruction.
- `reg_write`  in  1  register file written this cycle.
- `write_reg`  in  4  destination register.
- `write_data`  in  16  write-back data.
- `mem_read`  in  1  load this cycle.
- `mem_write`  in  1  store this cycle.
- `mem_addr`  in  16  memory address (ALU output).
- `mem_data`  in  16  store data.
- `hlt`  in  1  halt retiring.
- `ev_valid`  out  1  FIFO head valid.
- `ev_ready`  in  1  consumer accepts head.
- `ev_kind`  out  2  0 = NOP/branch, 1 = REG, 2 = STORE, 3 = HALT.
- `ev_load`  out  1  REG event was a load.
- `ev_inum`  out  32  instruction number.
- `ev_pc`  out  16  event PC.
- `ev_reg`  out  4  destination register (REG only, else 0).
- `ev_addr`  out  16  memory address (load/STORE only, else 0).
- `ev_value`  out  16  write-back data (REG) or store data (STORE), else 0.
- `inst_count`  out  32  events numbered so far.
- `cycle_count`  out  32  capture cycles elapsed.
- `drop_count`  out  16  events lost to full FIFO; saturates at 0xFFFF.
- `halted`  out  1  HALT captured; sticky.
- `timeout`  out  1  `MAX_CYCLES` reached; sticky.

## Operation
- Capture is active when `rst_n`=1, `halted`=0, `timeout`=0, and no HALT is pending. Exactly one event is classified per active cycle.
- Classification priority: `reg_write` → REG (`ev_load`=`mem_read`); else `hlt` → HALT; else `mem_write` → STORE; else NOP.
- Each classified event gets `ev_inum` = current `inst_count`, then `inst_count` increments. Numbering starts at 0 and is gap-free even when events are dropped.
- Push/pop rules:
  - FIFO not full: push.
  - FIFO full and non-HALT: event is dropped and `drop_count` increments. A pop in the same cycle does not rescue it: full is evaluated before the pop.
  - HALT is never dropped. If the FIFO is full, HALT is latched as pending, capture stops, and it is pushed on the first cycle with space.
  - `halted` sets when HALT is pushed.
- Pop: `ev_valid && ev_ready` removes the head. Simultaneous push and pop on a non-full FIFO keeps occupancy unchanged.
- Pointers: `log2(DEPTH)`-bit, wrapping naturally. Full/empty are tracked with an extra wrap bit.
- `cycle_count` increments every active cycle. When it equals `MAX_CYCLES - 1` and increments, `timeout` sets and capture stops. Already-queued events still drain.
- States: CAPTURE, HALT_PEND, STOPPED.
  - CAPTURE → HALT_PEND on HALT with FIFO full.
  - CAPTURE → STOPPED on HALT pushed or on timeout.
  - HALT_PEND → STOPPED on push.
  - STOPPED exits only via reset.

## Timing
- Reset (`rst_n`=0 at a rising edge) clears the pointers, all counters, `halted`, `timeout`, and any pending HALT. State goes to CAPTURE.
- Outputs after reset: `ev_valid`=0, all `ev_*` fields 0, all counters 0. Reset mid-drain discards queued events.
- Inputs are sampled at rising edge N. The event is visible on `ev_*` with `ev_valid`=1 after edge N (one-cycle latency into an empty FIFO).
- `ev_*` are driven from FIFO head storage. They hold stable while `ev_valid`=1 and `ev_ready`=0.
- Counters and flags update at the same edge as the capture.
- Throughput: one event per cycle sustained when `ev_ready`=1 every cycle.

## Configuration
- `RETIRE_TRACE_NOP_FILTER_EN` defined: NOP-class cycles are neither enqueued nor numbered, so `inst_count` advances only on REG/STORE/HALT. `cycle_count` still advances.
- Macro undefined: NOP events are enqueued and numbered as described above.

## Test plan
- Reset, `ev_ready`=1, drive REG r3=0x1234 at PC 0x0000, STORE addr 0x0010 data 0xBEEF at PC 0x0002, HALT at PC 0x0004. Required response:
  - Three events with inum 0/1/2 and kinds 1/2/3.
  - `halted`=1 and `inst_count`=3.
- `ev_ready`=0 and 10 REG events with `DEPTH`=8. Required response:
  - 8 queued, `drop_count`=2, `inst_count`=10.
  - Draining yields inum 0..7 in order.
- FIFO full, then HALT asserted, then `ev_ready` pulsed once. Required response:
  - HALT is enqueued one cycle after the pop.
  - `halted`=1, `drop_count` unchanged, no further captures.
- `MAX_CYCLES`=16 with NOPs only. Required response:
  - `timeout`=1 after the 16th active cycle, `cycle_count`=16, capture frozen.
  - Queued events still drain.
- Reset asserted with 5 events queued. Required response:
  - Next cycle `ev_valid`=0 and all counters 0.
  - The next event captured has inum 0.
- With `RETIRE_TRACE_NOP_FILTER_EN`, alternate NOP and REG for 6 cycles. Required response:
  - 3 REG events, inum 0..2.
  - `inst_count`=3, `cycle_count`=6.
